// File: rtl/cpu_mem_pkg.sv
// Shared types and constants for the cpu memory / bus responder.
package cpu_mem_pkg;

    typedef enum logic [1:0] {
        ST_LOAD = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    // MMIO register offsets within the 64 KiB window
    localparam logic [15:0] TX_OFF   = 16'h0000;
    localparam logic [15:0] HALT_OFF = 16'h0004;

    // Address slicing: byte address -> word index, and MMIO window decode bits
    localparam int WORD_LSB = 2;
    localparam int MMIO_LSB = 16;

endpackage

// File: rtl/cpu_mem_if.sv
// CPU-side fetch / read / write port bundle; master = cpu core, slave = cpu_mem.
interface cpu_mem_if;
    logic [31:0] pc_addr;
    logic [31:0] pc_data;
    logic [31:0] rd_addr;
    logic [31:0] rd_data;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        wr_valid;

    modport master (
        output pc_addr, rd_addr, wr_addr, wr_data, wr_valid,
        input  pc_data, rd_data
    );

    modport slave (
        input  pc_addr, rd_addr, wr_addr, wr_data, wr_valid,
        output pc_data, rd_data
    );
endinterface

// File: rtl/cpu_mem_txfifo.sv
// Console TX byte FIFO: circular buffer with occupancy count 0..DEPTH.
module cpu_mem_txfifo #(
    parameter  int DEPTH = 4,
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          i_reset,
    input  logic          push_i,
    input  logic [7:0]    data_i,
    input  logic          pop_i,
    output logic [7:0]    data_o,
    output logic          full_o,
    output logic          empty_o,
    output logic [CW-1:0] count_o
);

    logic [7:0]    buf_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q;
    logic          do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = buf_q[rd_ptr_q];

    // A push into a full FIFO still succeeds when the head leaves in the same cycle
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Pointer and occupancy bookkeeping; pointers wrap naturally (power-of-two depth)
    always_ff @(posedge clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (do_push && !do_pop)      count_q <= count_q + 1'b1;
            else if (!do_push && do_pop) count_q <= count_q - 1'b1;
        end
    end

    // Storage is not reset; only entries between the pointers are meaningful
    always_ff @(posedge clk) begin
        if (do_push) buf_q[wr_ptr_q] <= data_i;
    end

endmodule

// File: rtl/cpu_mem.sv
// Program/data RAM, host loader, MMIO console + halt, and run control for the cpu core.
module cpu_mem
    import cpu_mem_pkg::*;
#(
    parameter int          MEM_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE = 32'hFFFF0000,
    parameter int          TX_DEPTH  = 4
) (
    input  logic        clk,
    input  logic        i_reset,
    input  logic        i_ld_valid,
    input  logic [31:0] i_ld_data,
    input  logic        i_ld_last,
    output logic        o_ld_ready,
    cpu_mem_if.slave    bus,
    output logic        o_running,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    input  logic        i_tx_ready,
    output logic        o_fault
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int CW = $clog2(TX_DEPTH) + 1;

    state_t        state_q, state_d;
    logic [AW-1:0] ld_ptr_q, ld_ptr_d;
    logic          fault_q, fault_d;
    logic [31:0]   mem [MEM_WORDS];

    logic          pc_mmio, pc_in, rd_mmio, rd_in, wr_mmio, wr_in;
    logic          wr_en, wr_mem, wr_tx, wr_halt, wr_bad;
    logic          ld_fire;
    logic          tx_full, tx_empty, tx_pop, tx_drop;
    logic [CW-1:0] tx_count_unused;
    logic          addr_lsb_unused;

    // Address decode: MMIO window on the upper half-word, RAM below MEM_WORDS*4
    assign pc_mmio = (bus.pc_addr[31:MMIO_LSB] == MMIO_BASE[31:MMIO_LSB]);
    assign rd_mmio = (bus.rd_addr[31:MMIO_LSB] == MMIO_BASE[31:MMIO_LSB]);
    assign wr_mmio = (bus.wr_addr[31:MMIO_LSB] == MMIO_BASE[31:MMIO_LSB]);
    assign pc_in   = !pc_mmio && (bus.pc_addr[31:AW+WORD_LSB] == '0);
    assign rd_in   = !rd_mmio && (bus.rd_addr[31:AW+WORD_LSB] == '0);
    assign wr_in   = !wr_mmio && (bus.wr_addr[31:AW+WORD_LSB] == '0);
    assign addr_lsb_unused = ^{bus.pc_addr[1:0], bus.rd_addr[1:0], bus.wr_addr[1:0]};

    // Writes only count while running; byte lanes within a word are not decoded
    assign wr_en   = bus.wr_valid && (state_q == ST_RUN) && !i_reset;
    assign wr_mem  = wr_en && wr_in;
    assign wr_tx   = wr_en && wr_mmio && (bus.wr_addr[15:WORD_LSB] == TX_OFF[15:WORD_LSB]);
    assign wr_halt = wr_en && wr_mmio && (bus.wr_addr[15:WORD_LSB] == HALT_OFF[15:WORD_LSB]);
    assign wr_bad  = wr_en && !(wr_mem || wr_tx || wr_halt);

    assign ld_fire = (state_q == ST_LOAD) && i_ld_valid && !i_reset;

    assign bus.pc_data = pc_in ? mem[bus.pc_addr[AW+1:WORD_LSB]] : 32'h0;
    assign bus.rd_data = rd_in ? mem[bus.rd_addr[AW+1:WORD_LSB]] : 32'h0;

    assign tx_pop    = o_tx_valid && i_tx_ready;
    assign tx_drop   = wr_tx && tx_full && !tx_pop;
    assign o_tx_valid = !tx_empty;
    assign o_running = (state_q == ST_RUN) && !tx_full;
    assign o_fault   = fault_q;

    cpu_mem_txfifo #(.DEPTH(TX_DEPTH)) u_txfifo (
        .clk     (clk),
        .i_reset (i_reset),
        .push_i  (wr_tx),
        .data_i  (bus.wr_data[7:0]),
        .pop_i   (tx_pop),
        .data_o  (o_tx_data),
        .full_o  (tx_full),
        .empty_o (tx_empty),
        .count_o (tx_count_unused)
    );

    // RAM write port shared by the host loader (LOAD) and cpu stores (RUN)
    always_ff @(posedge clk) begin
        if (ld_fire)     mem[ld_ptr_q] <= i_ld_data;
        else if (wr_mem) mem[bus.wr_addr[AW+1:WORD_LSB]] <= bus.wr_data;
    end

    // Control registers: state, load pointer, sticky fault
    always_ff @(posedge clk) begin
        if (i_reset) begin
            state_q  <= ST_LOAD;
            ld_ptr_q <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_ptr_q <= ld_ptr_d;
            fault_q  <= fault_d;
        end
    end

    // Next-state logic and load handshake
    always_comb begin
        state_d    = state_q;
        ld_ptr_d   = ld_ptr_q;
        o_ld_ready = 1'b0;
        fault_d    = fault_q | wr_bad | tx_drop | (o_running && !pc_in);
        case (state_q)
            ST_LOAD: begin
                o_ld_ready = 1'b1;
                if (i_ld_valid) begin
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    if (i_ld_last || (ld_ptr_q == AW'(MEM_WORDS - 1))) state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (wr_halt) state_d = ST_HALT;
            end
            ST_HALT: begin
                state_d = ST_HALT;
            end
            default: state_d = ST_LOAD;
        endcase
    end

endmodule

// File: tb/tb_cpu_mem.sv
// Directed self-checking bench for cpu_mem.
module tb_cpu_mem;
    import cpu_mem_pkg::*;

    localparam int          MEM_WORDS = 1024;
    localparam logic [31:0] MMIO_BASE = 32'hFFFF0000;

    logic        clk = 1'b0;
    logic        i_reset;
    logic        i_ld_valid;
    logic [31:0] i_ld_data;
    logic        i_ld_last;
    logic        o_ld_ready;
    logic        o_running;
    logic [7:0]  o_tx_data;
    logic        o_tx_valid;
    logic        i_tx_ready;
    logic        o_fault;

    int tests = 0;
    int fails = 0;

    cpu_mem_if bus ();

    cpu_mem #(.MEM_WORDS(MEM_WORDS), .MMIO_BASE(MMIO_BASE), .TX_DEPTH(4)) dut (
        .clk        (clk),
        .i_reset    (i_reset),
        .i_ld_valid (i_ld_valid),
        .i_ld_data  (i_ld_data),
        .i_ld_last  (i_ld_last),
        .o_ld_ready (o_ld_ready),
        .bus        (bus),
        .o_running  (o_running),
        .o_tx_data  (o_tx_data),
        .o_tx_valid (o_tx_valid),
        .i_tx_ready (i_tx_ready),
        .o_fault    (o_fault)
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge
    task automatic clk1();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        i_reset = 1'b1;
        i_ld_valid = 1'b0; i_ld_data = '0; i_ld_last = 1'b0;
        i_tx_ready = 1'b0;
        bus.pc_addr = '0; bus.rd_addr = '0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.wr_valid = 1'b0;
        clk1(); clk1();
        i_reset = 1'b0;
    endtask

    task automatic cpu_write(input logic [31:0] a, input logic [31:0] d);
        bus.wr_addr = a; bus.wr_data = d; bus.wr_valid = 1'b1;
        clk1();
        bus.wr_valid = 1'b0;
    endtask

    task automatic load_one_word(input logic [31:0] d);
        i_ld_valid = 1'b1; i_ld_data = d; i_ld_last = 1'b1;
        clk1();
        i_ld_valid = 1'b0; i_ld_last = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++; if (o_ld_ready !== 1'b1) begin fails++; $display("FAIL reset_ld_ready: got %b want 1", o_ld_ready); end
        tests++; if (o_running !== 1'b0) begin fails++; $display("FAIL reset_running: got %b want 0", o_running); end
        tests++; if (o_tx_valid !== 1'b0) begin fails++; $display("FAIL reset_tx_valid: got %b want 0", o_tx_valid); end
        tests++; if (o_fault !== 1'b0) begin fails++; $display("FAIL reset_fault: got %b want 0", o_fault); end
    endtask

    task automatic test_load_short();
        logic [31:0] words [3];
        words[0] = 32'hE3A01041; words[1] = 32'hE3A02002; words[2] = 32'h00000000;
        for (int i = 0; i < 3; i++) begin
            i_ld_valid = 1'b1; i_ld_data = words[i]; i_ld_last = (i == 2);
            tests++; if (o_ld_ready !== 1'b1) begin fails++; $display("FAIL load_ready_beat%0d: got %b want 1", i, o_ld_ready); end
            clk1();
        end
        i_ld_valid = 1'b0; i_ld_last = 1'b0;
        tests++; if (o_ld_ready !== 1'b0) begin fails++; $display("FAIL load_ready_after_last: got %b want 0", o_ld_ready); end
        tests++; if (o_running !== 1'b1) begin fails++; $display("FAIL load_running: got %b want 1", o_running); end
        bus.pc_addr = 32'h4; #1;
        tests++; if (bus.pc_data !== 32'hE3A02002) begin fails++; $display("FAIL fetch_pc4: got %h want e3a02002", bus.pc_data); end
        bus.pc_addr = 32'h0; bus.rd_addr = 32'h0; #1;
        tests++; if (bus.rd_data !== 32'hE3A01041) begin fails++; $display("FAIL read_addr0: got %h want e3a01041", bus.rd_data); end
    endtask

    task automatic test_tx_single();
        i_tx_ready = 1'b1;
        cpu_write(MMIO_BASE, 32'h00000041);
        tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== 8'h41) begin fails++; $display("FAIL tx_single_head: got v=%b d=%h want v=1 d=41", o_tx_valid, o_tx_data); end
        clk1();
        tests++; if (o_tx_valid !== 1'b0) begin fails++; $display("FAIL tx_single_popped: got %b want 0", o_tx_valid); end
        i_tx_ready = 1'b0;
    endtask

    task automatic test_back_pressure();
        logic [7:0] exp_b;
        i_tx_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tests++; if (o_running !== 1'b1) begin fails++; $display("FAIL bp_running_before_%0d: got %b want 1", i, o_running); end
            cpu_write(MMIO_BASE, 32'h00000061 + i);
        end
        tests++; if (o_running !== 1'b0) begin fails++; $display("FAIL bp_running_full: got %b want 0", o_running); end
        tests++; if (o_tx_data !== 8'h61) begin fails++; $display("FAIL bp_head_full: got %h want 61", o_tx_data); end
        i_tx_ready = 1'b1; clk1(); i_tx_ready = 1'b0;
        tests++; if (o_running !== 1'b1) begin fails++; $display("FAIL bp_running_after_pop: got %b want 1", o_running); end
        i_tx_ready = 1'b1;
        for (int i = 1; i < 4; i++) begin
            exp_b = 8'h61 + 8'(i);
            tests++; if (o_tx_valid !== 1'b1 || o_tx_data !== exp_b) begin fails++; $display("FAIL bp_order_%0d: got v=%b d=%h want v=1 d=%h", i, o_tx_valid, o_tx_data, exp_b); end
            clk1();
        end
        i_tx_ready = 1'b0;
        tests++; if (o_tx_valid !== 1'b0) begin fails++; $display("FAIL bp_drained: got %b want 0", o_tx_valid); end
        tests++; if (o_fault !== 1'b0) begin fails++; $display("FAIL bp_no_fault: got %b want 0", o_fault); end
    endtask

    task automatic test_mem_halt();
        cpu_write(32'h10, 32'hDEADBEEF);
        bus.rd_addr = 32'h10; #1;
        tests++; if (bus.rd_data !== 32'hDEADBEEF) begin fails++; $display("FAIL rd_after_wr: got %h want deadbeef", bus.rd_data); end
        cpu_write(MMIO_BASE + 32'h4, 32'h12345678);
        tests++; if (o_running !== 1'b0 || o_ld_ready !== 1'b0) begin fails++; $display("FAIL halt_entered: got run=%b rdy=%b want 0 0", o_running, o_ld_ready); end
        cpu_write(32'h10, 32'h11111111);
        cpu_write(MMIO_BASE, 32'h00000055);
        cpu_write(32'h00002000, 32'h0);
        bus.pc_addr = 32'h8000; clk1(); clk1();
        tests++; if (bus.rd_data !== 32'hDEADBEEF) begin fails++; $display("FAIL halt_wr_ignored: got %h want deadbeef", bus.rd_data); end
        tests++; if (o_tx_valid !== 1'b0) begin fails++; $display("FAIL halt_tx_ignored: got %b want 0", o_tx_valid); end
        tests++; if (o_fault !== 1'b0 || o_running !== 1'b0) begin fails++; $display("FAIL halt_quiet: got fault=%b run=%b want 0 0", o_fault, o_running); end
        bus.pc_addr = 32'h0;
    endtask

    task automatic test_load_full();
        do_reset();
        for (int i = 0; i < MEM_WORDS; i++) begin
            i_ld_valid = 1'b1; i_ld_data = 32'hA5A50000 | i; i_ld_last = 1'b0;
            if (i == MEM_WORDS - 1) begin
                tests++; if (o_ld_ready !== 1'b1) begin fails++; $display("FAIL full_last_beat_ready: got %b want 1", o_ld_ready); end
            end
            clk1();
        end
        i_ld_data = 32'h00000BAD;
        tests++; if (o_ld_ready !== 1'b0) begin fails++; $display("FAIL full_extra_ready: got %b want 0", o_ld_ready); end
        tests++; if (o_running !== 1'b1) begin fails++; $display("FAIL full_running: got %b want 1", o_running); end
        clk1();
        i_ld_valid = 1'b0;
        bus.rd_addr = 32'hFFC; #1;
        tests++; if (bus.rd_data !== 32'hA5A503FF) begin fails++; $display("FAIL full_last_word: got %h want a5a503ff", bus.rd_data); end
        bus.rd_addr = 32'h0; #1;
        tests++; if (bus.rd_data !== 32'hA5A50000) begin fails++; $display("FAIL full_no_overwrite: got %h want a5a50000", bus.rd_data); end
    endtask

    task automatic test_faults();
        do_reset();
        load_one_word(32'h0);
        cpu_write(32'hFFC, 32'h000055AA);
        bus.rd_addr = 32'hFFC; #1;
        tests++; if (bus.rd_data !== 32'h000055AA || o_fault !== 1'b0) begin fails++; $display("FAIL top_word_ok: got d=%h f=%b want 000055aa 0", bus.rd_data, o_fault); end
        cpu_write(32'h1000, 32'hFFFFFFFF);
        tests++; if (o_fault !== 1'b1) begin fails++; $display("FAIL wr_oor_fault: got %b want 1", o_fault); end
        clk1(); clk1();
        tests++; if (o_fault !== 1'b1) begin fails++; $display("FAIL fault_sticky: got %b want 1", o_fault); end
        do_reset();
        tests++; if (o_fault !== 1'b0 || o_ld_ready !== 1'b1 || o_running !== 1'b0) begin fails++; $display("FAIL reset_clears: got f=%b rdy=%b run=%b want 0 1 0", o_fault, o_ld_ready, o_running); end
        load_one_word(32'h0);
        bus.pc_addr = 32'h8000; #1;
        tests++; if (bus.pc_data !== 32'h0) begin fails++; $display("FAIL fetch_oor_data: got %h want 0", bus.pc_data); end
        clk1();
        bus.pc_addr = 32'h0;
        tests++; if (o_fault !== 1'b1) begin fails++; $display("FAIL fetch_oor_fault: got %b want 1", o_fault); end
        do_reset();
        load_one_word(32'h0);
        cpu_write(MMIO_BASE + 32'h8, 32'h0);
        tests++; if (o_fault !== 1'b1) begin fails++; $display("FAIL mmio_bad_off: got %b want 1", o_fault); end
        do_reset();
        load_one_word(32'h0);
        for (int i = 0; i < 5; i++) cpu_write(MMIO_BASE, 32'h00000070 + i);
        tests++; if (o_fault !== 1'b1 || o_tx_data !== 8'h70) begin fails++; $display("FAIL overflow_drop: got f=%b d=%h want 1 70", o_fault, o_tx_data); end
    endtask

    initial begin
        test_reset();
        test_load_short();
        test_tx_single();
        test_back_pressure();
        test_mem_halt();
        test_load_full();
        test_faults();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/cpu_mem.md
Name: cpu_mem

Overview:
Memory and bus responder for the cpu core; it is the far end of the cpu's pc/rd/wr ports.
- Holds a word-addressed program/data RAM, loaded from a host stream before the cpu runs.
- Answers instruction fetches and data reads combinationally, and commits single-cycle writes.
- Decodes an MMIO region holding a console TX FIFO and a halt register.
- Generates the cpu's i_running, so it can start the core, stall it on console back-pressure, and stop it.

Parameters:
MEM_WORDS, 1024, RAM depth in 32-bit words (power of two); AW = log2(MEM_WORDS).
MMIO_BASE, 32'hFFFF0000, base address of the MMIO region (64 KiB window, decoded on addr[31:16]).
TX_DEPTH, 4, console FIFO depth (power of two).

Ports:
clk  in  1  clock
i_reset  in  1  synchronous, active-high reset
i_ld_valid  in  1  host load beat valid
i_ld_data  in  32  host load word
i_ld_last  in  1  final load beat
o_ld_ready  out  1  load beat accepted when valid&ready
pc_addr  in  32  cpu fetch byte address
pc_data  out  32  fetched instruction
rd_addr  in  32  cpu data read byte address
rd_data  out  32  read data
wr_addr  in  32  cpu write byte address
wr_data  in  32  cpu write data
wr_valid  in  1  one-cycle write strobe
o_running  out  1  drives cpu i_running
o_tx_data  out  8  console byte (FIFO head)
o_tx_valid  out  1  FIFO non-empty
i_tx_ready  in  1  consumer pops head when valid&ready
o_fault  out  1  sticky error flag

Behaviour:
- Reset is synchronous on clk, i_reset active-high.
  - Reset values: state=LOAD, ld_ptr=0, FIFO empty, o_fault=0, o_running=0, o_ld_ready=1, o_tx_valid=0.
  - RAM contents are not cleared.
- Word index: idx = addr[AW+1:2]; addr[1:0] ignored (word access only).
- MMIO hit: addr[31:16]==MMIO_BASE[31:16].
- In range: !MMIO hit && addr < MEM_WORDS*4.
- FSM states LOAD, RUN, HALT.
  - LOAD: o_ld_ready=1. Each accepted beat writes mem[ld_ptr] and increments ld_ptr. Leave for RUN after the beat with i_ld_last=1, or after the beat written at ld_ptr=MEM_WORDS-1 (full; any further beats not accepted). Transition takes effect the next cycle.
  - RUN: o_ld_ready=0. Remain in RUN until the halt write is accepted.
  - HALT: o_ld_ready=0, o_running=0. Exit only via i_reset.
- o_running = (state==RUN) && !fifo_full.
  - Combinational from registered state/count.
  - Deasserts the cycle after the FIFO fills; reasserts the cycle after a pop frees an entry.
- Fetch/read: pc_data and rd_data are combinational (async read) of the current address, zero latency.
  - Out-of-range or MMIO: return 0.
  - Out-of-range fetch with o_running=1 sets o_fault.
  - rd_addr is not validated; it has no strobe.
- Write: honoured only when wr_valid && state==RUN; committed at that clk edge.
  - In-range address: mem[idx] <= wr_data.
  - MMIO offset 0x0: push wr_data[7:0] into the TX FIFO.
  - MMIO offset 0x4: state -> HALT next cycle; wr_data ignored.
  - Other MMIO offset or out of range: ignored, o_fault <= 1.
  - wr_valid in LOAD/HALT: ignored, no fault.
- TX FIFO: circular, count 0..TX_DEPTH.
  - Push and pop in the same cycle: count unchanged, both happen.
  - Push when full without a simultaneous pop: byte dropped, o_fault <= 1.
  - Pointers wrap mod TX_DEPTH.
  - o_tx_data = head entry, valid only while o_tx_valid=1.
- o_fault is sticky until reset.
- Reset mid-load restarts at ld_ptr=0. Reset mid-run clears the FIFO and returns to LOAD.

Decomposition:
- Package cpu_mem_pkg holds:
  - state enum (LOAD, RUN, HALT);
  - MMIO offsets TX_OFF=0x0, HALT_OFF=0x4;
  - shared word-index helper constant widths.
- One sub-module, cpu_mem_txfifo: parameterised TX_DEPTH, push/pop/full/empty/count, used by cpu_mem.

Test Plan:
1. Load 3 words {E3A01041, E3A02002, 00000000} with last on beat 3 -> o_ld_ready drops, o_running=1 the next cycle; pc_addr=4 gives pc_data=E3A02002.
2. Load MEM_WORDS beats with no last -> the beat at index MEM_WORDS-1 is accepted, the next beat is not (o_ld_ready=0), state enters RUN.
3. In RUN, write 0x41 to MMIO_BASE with i_tx_ready=1 -> o_tx_valid=1 with o_tx_data=0x41 the next cycle, popped one cycle later.
4. Hold i_tx_ready=0 and write 4 bytes -> o_running=0 after the 4th. Pulse i_tx_ready once -> o_running=1 the next cycle. Bytes emerge in order with no fault.
5. Write 0xDEADBEEF to addr 0x10 -> rd_addr=0x10 returns DEADBEEF. Write to MMIO_BASE+4 -> o_running=0 permanently. Subsequent writes are ignored and o_fault stays 0.
6. Write to MEM_WORDS*4, or fetch pc_addr=0x8000 with MEM_WORDS=1024 -> o_fault=1 (sticky), pc_data=0. Assert i_reset -> o_fault=0, state LOAD.
